// File: rtl/sign_classifier.sv
// Finger-status debouncer with a runtime-loaded, priority-ordered pattern table.
// Emits one classification per stable episode of the finger vector.
module sign_classifier #(
    parameter int NUM_FINGERS   = 5,
    parameter int SIGN_W        = 4,
    parameter int NUM_ENTRIES   = 16,
    parameter int STABLE_CYCLES = 8,
    parameter int IDX_W         = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_FINGERS-1:0] finger_status,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic                   cfg_en,
    input  logic [NUM_FINGERS-1:0] cfg_pattern,
    input  logic [NUM_FINGERS-1:0] cfg_mask,
    input  logic [SIGN_W-1:0]      cfg_sign,
    output logic [SIGN_W-1:0]      sign_value,
    output logic                   sign_unknown,
    output logic                   sign_valid
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_FINGERS-1:0] samp;
    logic [CNT_W-1:0]       cnt;

    logic                   tbl_en   [NUM_ENTRIES];
    logic [NUM_FINGERS-1:0] tbl_pat  [NUM_ENTRIES];
    logic [NUM_FINGERS-1:0] tbl_mask [NUM_ENTRIES];
    logic [SIGN_W-1:0]      tbl_sign [NUM_ENTRIES];

    logic              same;
    logic              fire;
    logic              idx_ok;
    logic              hit;
    logic [SIGN_W-1:0] hit_sign;

    assign same   = (finger_status == samp);
    assign fire   = same && (cnt == CNT_FIRE);
    assign idx_ok = int'(cfg_idx) < NUM_ENTRIES;

    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= '0;
            cnt  <= '0;
        end else begin
            samp <= finger_status;
            if (!same) begin
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Table reads below see the pre-write contents on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                tbl_en[e]   <= 1'b0;
                tbl_pat[e]  <= '0;
                tbl_mask[e] <= '0;
                tbl_sign[e] <= '0;
            end
        end else if (cfg_we && idx_ok) begin
            tbl_en[cfg_idx]   <= cfg_en;
            tbl_pat[cfg_idx]  <= cfg_pattern;
            tbl_mask[cfg_idx] <= cfg_mask;
            tbl_sign[cfg_idx] <= cfg_sign;
        end
    end

    // Descending scan so the lowest matching index is the last to assign.
    always_comb begin
        hit      = 1'b0;
        hit_sign = '0;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            if (tbl_en[e] &&
                (((finger_status ^ tbl_pat[e]) & tbl_mask[e]) == '0)) begin
                hit      = 1'b1;
                hit_sign = tbl_sign[e];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_value   <= '0;
            sign_unknown <= 1'b0;
            sign_valid   <= 1'b0;
        end else begin
            sign_valid <= fire;
            if (fire) begin
                sign_value   <= hit ? hit_sign : '0;
                sign_unknown <= !hit;
            end
        end
    end

endmodule

// File: tb/tb_sign_classifier.sv
// Scoreboard bench for sign_classifier: stimulus pushes expected pulses,
// a monitor checks every cycle for pulse timing and held outputs.
module tb_sign_classifier;

    localparam int NF = 5;
    localparam int SW = 4;
    localparam int NE = 12;
    localparam int S  = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] finger_status = '0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic          cfg_en = 1'b0;
    logic [NF-1:0] cfg_pattern = '0;
    logic [NF-1:0] cfg_mask = '0;
    logic [SW-1:0] cfg_sign = '0;
    logic [SW-1:0] sign_value;
    logic          sign_unknown;
    logic          sign_valid;

    typedef struct {
        logic [SW-1:0] val;
        bit            unk;
        int            at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    sign_classifier #(
        .NUM_FINGERS(NF),
        .SIGN_W(SW),
        .NUM_ENTRIES(NE),
        .STABLE_CYCLES(S),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .finger_status(finger_status),
        .cfg_we(cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_en(cfg_en),
        .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask),
        .cfg_sign(cfg_sign),
        .sign_value(sign_value),
        .sign_unknown(sign_unknown),
        .sign_valid(sign_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: cycle-accurate pulse check plus held-output model.
    initial begin
        logic [SW-1:0] last_val;
        bit            last_unk;
        bit            r;
        bit            exp_v;
        exp_t          e;
        last_val = '0;
        last_unk = 1'b0;
        forever begin
            @(posedge clk);
            r = rst;
            cyc++;
            #1;
            if (r) begin
                last_val = '0;
                last_unk = 1'b0;
            end
            exp_v = !r && (q.size() > 0) && (q[0].at == cyc);
            checks++;
            if (sign_valid !== exp_v) begin
                failures++;
                $display("FAIL pulse @%0d: sign_valid=%b expected=%b",
                         cyc, sign_valid, exp_v);
            end
            if (exp_v) begin
                e = q.pop_front();
                last_val = e.val;
                last_unk = e.unk;
            end
            checks++;
            if (sign_value !== last_val || sign_unknown !== last_unk) begin
                failures++;
                $display("FAIL outputs @%0d: value=%0d unk=%b expected value=%0d unk=%b",
                         cyc, sign_value, sign_unknown, last_val, last_unk);
            end
        end
    end

    task automatic push(input logic [SW-1:0] v, input bit u, input int at);
        exp_t e;
        e.val = v;
        e.unk = u;
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input bit en,
                             input logic [NF-1:0] pat, input logic [NF-1:0] msk,
                             input logic [SW-1:0] sg);
        cfg_we      = 1'b1;
        cfg_idx     = idx;
        cfg_en      = en;
        cfg_pattern = pat;
        cfg_mask    = msk;
        cfg_sign    = sg;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_map();
        cfg_write(4'd0, 1'b1, 5'b00010, 5'b11111, 4'd1);
        cfg_write(4'd1, 1'b1, 5'b00110, 5'b11111, 4'd2);
        cfg_write(4'd2, 1'b1, 5'b00111, 5'b11111, 4'd3);
        cfg_write(4'd3, 1'b1, 5'b01111, 5'b11111, 4'd4);
        cfg_write(4'd4, 1'b1, 5'b11111, 5'b11111, 4'd5);
        cfg_write(4'd5, 1'b1, 5'b01110, 5'b11111, 4'd6);
        cfg_write(4'd6, 1'b1, 5'b10110, 5'b11111, 4'd7);
        cfg_write(4'd7, 1'b1, 5'b11010, 5'b11111, 4'd8);
        cfg_write(4'd8, 1'b1, 5'b11100, 5'b11111, 4'd9);
    endtask

    // Present a new pattern; a fire is expected S edges after first sample.
    task automatic present(input logic [NF-1:0] p, input int hold,
                           input bit fire, input logic [SW-1:0] v, input bit u);
        finger_status = p;
        if (fire) push(v, u, cyc + 1 + S);
        repeat (hold) @(negedge clk);
    endtask

    task automatic spacer();
        present(5'b10101, 2, 1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (sign_value !== '0 || sign_unknown !== 1'b0 || sign_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s: value=%0d unk=%b valid=%b expected 0 0 0",
                     tag, sign_value, sign_unknown, sign_valid);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");

        // All-zero input held from reset fires at the S-th edge after release.
        rst = 1'b0;
        push('0, 1'b1, cyc + S);
        load_map();
        repeat (S) @(negedge clk);

        // Basic, then glitch reject.
        spacer();
        present(5'b00110, S + 3, 1'b1, 4'd2, 1'b0);
        present(5'b01111, 5, 1'b0, '0, 1'b0);
        present(5'b11111, S + 3, 1'b1, 4'd5, 1'b0);

        // Priority wildcard in entry0, then disable it.
        cfg_write(4'd0, 1'b1, 5'b00000, 5'b00001, 4'd12);
        present(5'b00110, S + 3, 1'b1, 4'd12, 1'b0);
        cfg_write(4'd0, 1'b0, 5'b00000, 5'b00001, 4'd12);
        spacer();
        present(5'b00110, S + 3, 1'b1, 4'd2, 1'b0);

        // Write on the exact fire edge is not seen by that classification.
        spacer();
        present(5'b00110, S, 1'b1, 4'd2, 1'b0);
        cfg_write(4'd1, 1'b1, 5'b00110, 5'b11111, 4'd14);
        repeat (3) @(negedge clk);
        spacer();
        present(5'b00110, 3, 1'b1, 4'd14, 1'b0);
        cfg_write(4'd9, 1'b0, 5'b00000, 5'b00000, 4'd0);
        repeat (S) @(negedge clk);

        // Unknown, then a full-mask match.
        present(5'b10001, S + 3, 1'b1, '0, 1'b1);
        present(5'b11100, S + 3, 1'b1, 4'd9, 1'b0);

        // Reset at cnt=5 with 00111 held.
        spacer();
        present(5'b00111, 6, 1'b0, '0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_midcount");
        @(negedge clk);
        rst = 1'b0;
        // Table is empty and out-of-range writes must not land anywhere.
        push('0, 1'b1, cyc + 1 + S);
        cfg_write(4'd12, 1'b1, 5'b00111, 5'b11111, 4'd15);
        cfg_write(4'd13, 1'b1, 5'b00111, 5'b11111, 4'd15);
        cfg_write(4'd14, 1'b1, 5'b00111, 5'b11111, 4'd15);
        cfg_write(4'd15, 1'b1, 5'b00111, 5'b00000, 4'd15);
        repeat (S) @(negedge clk);
        load_map();
        spacer();
        present(5'b00111, S + 3, 1'b1, 4'd3, 1'b0);
        spacer();
        present(5'b10001, S + 3, 1'b1, '0, 1'b1);

        repeat (S + 4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending: %0d expected pulses never seen, expected 0",
                     q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sign_classifier.md
Name: sign_classifier

Overview:
Parametrised successor to the fixed five-finger sign decoder. It samples an N-bit finger-status vector and requires the pattern to be held stable for a programmable number of cycles, which filters glitches and mid-gesture transitions. The stable pattern is then classified against a runtime-writable, priority-ordered pattern table with per-entry don't-care masks. The block sits between the per-finger status detectors and the downstream sign consumer (display or UART formatter).

Parameters:
NUM_FINGERS, 5, width of the finger-status vector (1..16)
SIGN_W, 4, width of the sign code
NUM_ENTRIES, 16, number of pattern-table entries (>=1)
STABLE_CYCLES, 8, consecutive equal samples required after the first sample (>=1)
IDX_W, $clog2(NUM_ENTRIES) (min 1), table index width

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  synchronous, active-high reset
finger_status  in  NUM_FINGERS  bit i = finger i extended (bit0 thumb, bit4 pinky)
cfg_we  in  1  table write strobe
cfg_idx  in  IDX_W  table entry to write
cfg_en  in  1  entry enable written with the entry
cfg_pattern  in  NUM_FINGERS  entry match pattern
cfg_mask  in  NUM_FINGERS  1 = bit compared, 0 = don't care
cfg_sign  in  SIGN_W  sign code returned on match
sign_value  out  SIGN_W  last classified sign (held)
sign_unknown  out  1  last classification found no match
sign_valid  out  1  one-cycle pulse per new classification

Behaviour:
- One clock domain. Reset is synchronous and active-high, on ports clk and rst.
- Reset clears the following: sign_value=0, sign_unknown=0, sign_valid=0, samp=0, cnt=0, cfg table (all en=0, all fields 0). A reset mid-count discards progress. A reset mid-table-load clears the entries already written.
- Sampler: samp <= finger_status every cycle.
- Stability counter cnt, width $clog2(STABLE_CYCLES+1):
  - If finger_status != samp, cnt <= 0.
  - Else if cnt < STABLE_CYCLES, cnt <= cnt+1.
  - Else cnt holds (saturates at STABLE_CYCLES).
- Fire condition: finger_status == samp and cnt == STABLE_CYCLES-1.
  - On that edge, sign_valid <= 1 and the outputs are updated.
  - At every other edge, sign_valid <= 0.
- Each stable episode fires exactly once. A pattern first sampled at edge k and held fires at edge k+STABLE_CYCLES. It must be present for STABLE_CYCLES+1 consecutive edges.
- Any change before the fire edge restarts the count; nothing is emitted for the aborted pattern.
- After reset samp=0, so an all-zero input held from reset fires at the STABLE_CYCLES-th edge after rst deasserts.
- Classification is combinational on finger_status at the fire edge:
  - Entry e matches if en[e] and ((finger_status ^ pattern[e]) & mask[e]) == 0.
  - The lowest-index matching entry wins: sign_value <= sign[e], sign_unknown <= 0.
  - If no entry matches: sign_value <= 0, sign_unknown <= 1.
- Between fires, sign_value and sign_unknown hold their values.
- Table write:
  - When cfg_we=1, entry cfg_idx <= {cfg_en, cfg_pattern, cfg_mask, cfg_sign} at the edge.
  - cfg_idx >= NUM_ENTRIES is ignored.
  - A write on the fire edge is not visible to that classification. It is used from the next edge on.
- A table write does not restart the stability count and does not re-classify the current stable pattern.
- An all-zero mask with en=1 matches every pattern. Use it as a catch-all in the last entry.
- Legacy map, loaded by software, not hardwired (pattern in pinky..thumb order, full mask):
  - entry0 00010->1, entry1 00110->2, entry2 00111->3
  - entry3 01111->4, entry4 11111->5, entry5 01110->6
  - entry6 10110->7, entry7 11010->8, entry8 11100->9

Test Plan:
- Basic: STABLE_CYCLES=8, load the legacy map, reset, drive 00110 held -> sign_valid single pulse at the 8th edge after first sample, sign_value=2, sign_unknown=0, no further pulse while held.
- Glitch reject: drive 01111 for 5 edges, then 11111 held -> no pulse for 01111; pulse with sign_value=5 exactly 8 edges after 11111 is first sampled.
- Unknown: table loaded, hold 10001 -> pulse with sign_value=0, sign_unknown=1. Then hold 11100 -> pulse with sign_value=9, sign_unknown=0.
- Priority and mask:
  - Write entry0 pattern=00000, mask=00001, sign=12, en=1 (thumb-down wildcard); hold 00110 -> sign_value=12, not 2.
  - Disable entry0 with en=0; re-present 00110 -> sign_value=2.
- Write collision: cfg_we to entry1 (sign=14) on the exact fire edge of 00110 -> sign_value=2. The next stable episode of 00110 yields 14. The cnt sequence is unaffected by the write.
- Reset mid-operation:
  - Assert rst at cnt=5 with 00111 held -> all outputs 0 the next cycle and table enables cleared.
  - Release rst with the input still 00111, reload the table -> fire occurs STABLE_CYCLES edges after the first post-reset sample. Out-of-range cfg_idx writes leave the table unchanged.
